// File: rtl/iq_const_scaler.sv
// ---------------------------------------------------------------------------
// iq_const_scaler
//
// Time-multiplexed constant-coefficient multiplier. A set of CHANNELS signed
// samples is scaled by the compile-time constant CONST_FACTOR through a single
// shared shift-add datapath. The constant is processed one bit per clock, LSB
// first. Each product is then rounded (half toward +inf), arithmetically
// shifted right by SHIFT and saturated to OUT_WIDTH bits. Results are
// collected in shadow slots and published together, so partial results are
// never visible on product_o.
//
// Ports
//   main_clk   in   1                    main clock
//   reset      in   1                    synchronous, active-high reset
//   data_i     in   CHANNELS*DATA_WIDTH  packed signed samples, channel 0 in LSBs
//   valid_i    in   1                    strobe: new sample set on data_i
//   product_o  out  CHANNELS*OUT_WIDTH   packed signed results, held between valid_o
//   valid_o    out  1                    one-cycle pulse when product_o updates
//   busy_o     out  1                    a sample set is in flight
//   overrun_o  out  1                    sticky: valid_i arrived while busy
//
// Latency from the accepting edge to the valid_o edge is
// CHANNELS*(COEF_WIDTH+1) clocks: COEF_WIDTH MAC cycles plus one ROUND cycle
// per channel.
// ---------------------------------------------------------------------------
module iq_const_scaler #(
    parameter int CHANNELS     = 2,
    parameter int DATA_WIDTH   = 10,
    parameter int COEF_WIDTH   = 8,
    parameter int CONST_FACTOR = 3,
    parameter int SHIFT        = 0,
    parameter int OUT_WIDTH    = 18
) (
    input  logic                           main_clk,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_WIDTH-1:0] data_i,
    input  logic                           valid_i,
    output logic [CHANNELS*OUT_WIDTH-1:0]  product_o,
    output logic                           valid_o,
    output logic                           busy_o,
    output logic                           overrun_o
);

    // Accumulator wide enough for the full product: never overflows.
    localparam int ACC_W = DATA_WIDTH + COEF_WIDTH;
    // One extra bit so the rounding offset can be added without overflow.
    localparam int RND_W = ACC_W + 1;
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BIT_W = $clog2(COEF_WIDTH);

    localparam logic [COEF_WIDTH-1:0] COEF_BITS = COEF_WIDTH'(CONST_FACTOR);
    localparam logic [CH_W-1:0]       LAST_CH   = CH_W'(CHANNELS - 1);
    localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(COEF_WIDTH - 1);

    // Saturation limits expressed at the rounding width.
    localparam logic signed [RND_W-1:0] SAT_MAX =
        {{(RND_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RND_W-1:0] SAT_MIN =
        {{(RND_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND
    } state_t;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    state_t                          state_reg,   state_next;
    logic [CHANNELS*DATA_WIDTH-1:0]  data_reg,    data_next;
    logic signed [ACC_W-1:0]         acc_reg,     acc_next;
    logic [CH_W-1:0]                 ch_reg,      ch_next;
    logic [BIT_W-1:0]                bit_reg,     bit_next;
    logic [CHANNELS*OUT_WIDTH-1:0]   shadow_reg,  shadow_next;
    logic [CHANNELS*OUT_WIDTH-1:0]   product_reg, product_next;
    logic                            valid_reg,   valid_next;
    logic                            busy_reg,    busy_next;
    logic                            overrun_reg, overrun_next;

    // -----------------------------------------------------------------------
    // Shared shift-add datapath
    // -----------------------------------------------------------------------
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [ACC_W-1:0]      sample_ext;
    logic signed [ACC_W-1:0]      addend;

    assign sample     = data_reg[ch_reg*DATA_WIDTH +: DATA_WIDTH];
    assign sample_ext = {{COEF_WIDTH{sample[DATA_WIDTH-1]}}, sample};
    assign addend     = sample_ext <<< bit_reg;

    // -----------------------------------------------------------------------
    // Round, shift and saturate the finished accumulator
    // -----------------------------------------------------------------------
    logic signed [RND_W-1:0]     acc_wide;
    logic signed [RND_W-1:0]     rounded;
    logic signed [OUT_WIDTH-1:0] sat;

    assign acc_wide = {acc_reg[ACC_W-1], acc_reg};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RND_W-1:0] HALF = RND_W'(1) << (SHIFT - 1);
            // Adding half an LSB before an arithmetic (floor) shift rounds
            // ties toward +inf.
            assign rounded = (acc_wide + HALF) >>> SHIFT;
        end else begin : g_no_round
            assign rounded = acc_wide;
        end
    endgenerate

    always_comb begin
        sat = rounded[OUT_WIDTH-1:0];
        if (rounded > SAT_MAX) begin
            sat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (rounded < SAT_MIN) begin
            sat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // Shadow slots: the current channel's slot takes the saturated result in
    // ROUND. product_o is loaded from shadow_next so the last channel's
    // result is included in the same cycle it is produced.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_shadow
            assign shadow_next[gi*OUT_WIDTH +: OUT_WIDTH] =
                (state_reg == ROUND && ch_reg == CH_W'(gi))
                    ? sat
                    : shadow_reg[gi*OUT_WIDTH +: OUT_WIDTH];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        data_next    = data_reg;
        acc_next     = acc_reg;
        ch_next      = ch_reg;
        bit_next     = bit_reg;
        product_next = product_reg;
        valid_next   = 1'b0;
        busy_next    = busy_reg;
        overrun_next = overrun_reg;

        // busy_reg is high exactly when state_reg is not IDLE, so this only
        // flags strobes that the IDLE branch below does not accept.
        if (valid_i && busy_reg) begin
            overrun_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    data_next  = data_i;
                    acc_next   = '0;
                    ch_next    = '0;
                    bit_next   = '0;
                    busy_next  = 1'b1;
                    state_next = MAC;
                end
            end

            MAC: begin
                if (COEF_BITS[bit_reg]) begin
                    // The coefficient MSB carries negative weight.
                    if (bit_reg == LAST_BIT) begin
                        acc_next = acc_reg - addend;
                    end else begin
                        acc_next = acc_reg + addend;
                    end
                end
                if (bit_reg == LAST_BIT) begin
                    bit_next   = '0;
                    state_next = ROUND;
                end else begin
                    bit_next = bit_reg + 1'b1;
                end
            end

            ROUND: begin
                acc_next = '0;
                if (ch_reg == LAST_CH) begin
                    product_next = shadow_next;
                    valid_next   = 1'b1;
                    busy_next    = 1'b0;
                    state_next   = IDLE;
                end else begin
                    ch_next    = ch_reg + 1'b1;
                    state_next = MAC;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge main_clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            data_reg    <= '0;
            acc_reg     <= '0;
            ch_reg      <= '0;
            bit_reg     <= '0;
            shadow_reg  <= '0;
            product_reg <= '0;
            valid_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            data_reg    <= data_next;
            acc_reg     <= acc_next;
            ch_reg      <= ch_next;
            bit_reg     <= bit_next;
            shadow_reg  <= shadow_next;
            product_reg <= product_next;
            valid_reg   <= valid_next;
            busy_reg    <= busy_next;
            overrun_reg <= overrun_next;
        end
    end

    assign product_o = product_reg;
    assign valid_o   = valid_reg;
    assign busy_o    = busy_reg;
    assign overrun_o = overrun_reg;

endmodule

// File: tb/tb_iq_const_scaler.sv
// ---------------------------------------------------------------------------
// Testbench for iq_const_scaler. Four instances with different parameter
// sets share clock, reset and the data bus; each has its own valid strobe.
//   0: defaults (x3, no shift, 18-bit out)
//   1: CONST_FACTOR = -128
//   2: CONST_FACTOR = 3, SHIFT = 2, OUT_WIDTH = 10
//   3: CONST_FACTOR = 127, OUT_WIDTH = 12 (saturating)
// ---------------------------------------------------------------------------
module tb_iq_const_scaler;

    localparam int LAT = 18;

    logic        main_clk = 1'b0;
    logic        reset;
    logic [19:0] data;
    logic [3:0]  valid;

    logic [35:0] prod_def;
    logic [35:0] prod_neg;
    logic [19:0] prod_rnd;
    logic [23:0] prod_sat;
    logic [3:0]  vo;
    logic [3:0]  bo;
    logic [3:0]  oo;

    always #5 main_clk = ~main_clk;

    iq_const_scaler u_def (
        .main_clk(main_clk), .reset(reset), .data_i(data), .valid_i(valid[0]),
        .product_o(prod_def), .valid_o(vo[0]), .busy_o(bo[0]), .overrun_o(oo[0])
    );

    iq_const_scaler #(.CONST_FACTOR(-128)) u_neg (
        .main_clk(main_clk), .reset(reset), .data_i(data), .valid_i(valid[1]),
        .product_o(prod_neg), .valid_o(vo[1]), .busy_o(bo[1]), .overrun_o(oo[1])
    );

    iq_const_scaler #(.CONST_FACTOR(3), .SHIFT(2), .OUT_WIDTH(10)) u_rnd (
        .main_clk(main_clk), .reset(reset), .data_i(data), .valid_i(valid[2]),
        .product_o(prod_rnd), .valid_o(vo[2]), .busy_o(bo[2]), .overrun_o(oo[2])
    );

    iq_const_scaler #(.CONST_FACTOR(127), .OUT_WIDTH(12)) u_sat (
        .main_clk(main_clk), .reset(reset), .data_i(data), .valid_i(valid[3]),
        .product_o(prod_sat), .valid_o(vo[3]), .busy_o(bo[3]), .overrun_o(oo[3])
    );

    // Per-instance channel results, sign-extended to int.
    int p0 [4];
    int p1 [4];
    always_comb begin
        p0[0] = $signed(prod_def[17:0]);
        p1[0] = $signed(prod_def[35:18]);
        p0[1] = $signed(prod_neg[17:0]);
        p1[1] = $signed(prod_neg[35:18]);
        p0[2] = $signed(prod_rnd[9:0]);
        p1[2] = $signed(prod_rnd[19:10]);
        p0[3] = $signed(prod_sat[11:0]);
        p1[3] = $signed(prod_sat[23:12]);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Waits for valid_o of instance d, counting edges from start_edge.
    // Returns the edge number on which valid_o appeared, or -1 on timeout.
    task automatic wait_valid(input int d, input int start_edge, output int edge_n);
        edge_n = -1;
        for (int i = start_edge + 1; i <= start_edge + 60; i++) begin
            @(posedge main_clk);
            #1;
            if (vo[d]) begin
                edge_n = i;
                break;
            end
        end
    endtask

    task automatic drive_set(input int d, input int c0, input int c1);
        data     = {10'(c1), 10'(c0)};
        valid[d] = 1'b1;
    endtask

    // One complete transaction on instance d.
    task automatic run_set(input int d, input int c0, input int c1,
                           input int e0, input int e1);
        int n;
        @(posedge main_clk);
        #1;
        drive_set(d, c0, c1);
        @(posedge main_clk);          // accepting edge
        #1;
        valid = '0;
        check("busy_rise", int'(bo[d]), 1);
        wait_valid(d, 0, n);
        check("latency", n, LAT);
        check("ch0", p0[d], e0);
        check("ch1", p1[d], e1);
        check("busy_fall", int'(bo[d]), 0);
        @(posedge main_clk);
        #1;
        check("valid_width", int'(vo[d]), 0);
        check("hold_ch0", p0[d], e0);
        $display("set dut=%0d in={%0d,%0d} out={%0d,%0d} exp={%0d,%0d} lat=%0d",
                 d, c0, c1, p0[d], p1[d], e0, e1, n);
    endtask

    typedef struct {
        int dut;
        int d0;
        int d1;
        int e0;
        int e1;
    } vec_t;

    vec_t vecs [12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;

        vecs[0]  = '{0,  100, -512,   300, -1536};
        vecs[1]  = '{0,    0,    0,     0,     0};
        vecs[2]  = '{0,   -1,  511,    -3,  1533};
        vecs[3]  = '{1, -512,  511, 65536, -65408};
        vecs[4]  = '{1,    1,   -1,  -128,   128};
        vecs[5]  = '{2,    5,   -5,     4,    -4};
        vecs[6]  = '{2,   -2,    0,    -1,     0};
        vecs[7]  = '{2,    1,    2,     1,     2};
        vecs[8]  = '{2, -511,  511,  -383,   383};
        vecs[9]  = '{3,  100, -100,  2047, -2048};
        vecs[10] = '{3,   10,  -10,  1270, -1270};
        vecs[11] = '{0, -512,  511, -1536,  1533};

        // Reset with a valid strobe present: the strobe must be ignored.
        reset = 1'b1;
        data  = 20'h00064;
        valid = 4'b1111;
        repeat (3) @(posedge main_clk);
        #1;
        reset = 1'b0;
        valid = '0;
        for (int d = 0; d < 4; d++) begin
            check("rst_valid",   int'(vo[d]), 0);
            check("rst_busy",    int'(bo[d]), 0);
            check("rst_overrun", int'(oo[d]), 0);
            check("rst_ch0",     p0[d], 0);
            check("rst_ch1",     p1[d], 0);
        end
        @(posedge main_clk);
        #1;
        check("rst_valid_ignored", int'(bo[0]), 0);

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            run_set(vecs[i].dut, vecs[i].d0, vecs[i].d1, vecs[i].e0, vecs[i].e1);
        end

        // Overrun: second strobe 5 cycles after acceptance is ignored.
        @(posedge main_clk);
        #1;
        drive_set(0, 7, -7);
        @(posedge main_clk);          // edge 0: accepted
        #1;
        valid = '0;
        repeat (4) @(posedge main_clk);
        #1;
        drive_set(0, 1, 1);
        @(posedge main_clk);          // edge 5: ignored
        #1;
        valid = '0;
        check("ovr_set", int'(oo[0]), 1);
        check("ovr_no_partial", p0[0], -1536);
        wait_valid(0, 5, n);
        check("ovr_latency", n, LAT);
        check("ovr_ch0", p0[0], 21);
        check("ovr_ch1", p1[0], -21);
        check("ovr_sticky", int'(oo[0]), 1);
        $display("overrun first set out={%0d,%0d} lat=%0d overrun=%0d", p0[0], p1[0], n, oo[0]);
        // Strobe during the valid_o cycle is accepted.
        drive_set(0, 2, -3);
        @(posedge main_clk);
        #1;
        valid = '0;
        check("b2b_busy", int'(bo[0]), 1);
        wait_valid(0, 0, n);
        check("b2b_latency", n, LAT);
        check("b2b_ch0", p0[0], 6);
        check("b2b_ch1", p1[0], -9);
        check("b2b_sticky", int'(oo[0]), 1);
        $display("back-to-back set out={%0d,%0d} lat=%0d", p0[0], p1[0], n);

        // Reset mid-operation aborts the set.
        @(posedge main_clk);
        #1;
        drive_set(0, 50, 50);
        @(posedge main_clk);
        #1;
        valid = '0;
        repeat (9) @(posedge main_clk);
        #1;
        reset = 1'b1;
        @(posedge main_clk);
        #1;
        reset = 1'b0;
        check("abort_valid",   int'(vo[0]), 0);
        check("abort_busy",    int'(bo[0]), 0);
        check("abort_overrun", int'(oo[0]), 0);
        check("abort_ch0",     p0[0], 0);
        check("abort_ch1",     p1[0], 0);
        n = 0;
        repeat (25) begin
            @(posedge main_clk);
            #1;
            if (vo[0]) n++;
        end
        check("abort_no_valid", n, 0);
        $display("reset abort: product={%0d,%0d} busy=%0d overrun=%0d", p0[0], p1[0], bo[0], oo[0]);
        run_set(0, 100, -512, 300, -1536);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/iq_const_scaler.md
# iq_const_scaler

Parametrised, time-multiplexed constant-coefficient multiplier for the receiver front end. It scales CHANNELS signed samples (I and Q by default) by a signed compile-time constant using one shared shift-add datapath, then rounds, shifts and saturates each product to the output width. It sits between the 1 MHz sample strobe and downstream filtering, and uses the 200 MHz main clock budget instead of hard multipliers.

## Interface
- CHANNELS, 2, number of channels per sample set (≥1); channel 0 occupies the LSBs of the packed buses
- DATA_WIDTH, 10, signed input sample width
- COEF_WIDTH, 8, signed coefficient width (≥2)
- CONST_FACTOR, 3, signed constant; must fit in COEF_WIDTH two's complement
- SHIFT, 0, arithmetic right shift applied after rounding (0 ≤ SHIFT < DATA_WIDTH+COEF_WIDTH)
- OUT_WIDTH, 18, signed output width per channel (≤ DATA_WIDTH+COEF_WIDTH)
- main_clk  in  1  main clock (200 MHz)
- reset  in  1  synchronous, active-high reset
- data_i  in  CHANNELS*DATA_WIDTH  packed signed samples, sampled when valid_i is accepted
- valid_i  in  1  one-cycle strobe, new sample set present
- product_o  out  CHANNELS*OUT_WIDTH  packed signed scaled results, held until next valid_o
- valid_o  out  1  one-cycle pulse, product_o updated
- busy_o  out  1  high while a sample set is in flight
- overrun_o  out  1  sticky, valid_i arrived while busy

## Operation
- One clock, main_clk; reset is synchronous and active-high. All outputs are 0 after reset.
- States: IDLE, MAC, ROUND.
- IDLE: valid_i=1 latches data_i into the input register, clears the accumulator, channel=0, bit=0, and moves to MAC.
- MAC: each cycle processes one coefficient bit, LSB first. If the bit is set, the accumulator adds the sign-extended sample << bit. The MSB (bit COEF_WIDTH-1) has negative weight and subtracts instead. The accumulator is DATA_WIDTH+COEF_WIDTH bits signed, so no overflow is possible. After bit COEF_WIDTH-1, go to ROUND.
- ROUND (1 cycle):
  - If SHIFT>0, r = (acc + 2^(SHIFT-1)) >>> SHIFT (round half toward +inf); otherwise r = acc.
  - r is saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and stored in the shadow slot for the current channel.
  - The accumulator is cleared. If more channels remain, increment the channel and return to MAC. Otherwise copy all shadow slots to product_o, pulse valid_o, and return to IDLE.
- product_o changes only on valid_o. Partial results are never visible.
- valid_i while busy_o=1 is ignored and sets overrun_o; overrun_o clears only on reset.
- Reset mid-operation aborts: no valid_o, product_o=0, state IDLE, overrun_o=0.
- valid_i in the same cycle as reset is ignored.
- CONST_FACTOR=0 yields 0. Negative CONST_FACTOR, including the most negative value -2^(COEF_WIDTH-1), is exact.

## Timing
- Latency L = CHANNELS*(COEF_WIDTH+1) clock edges from the edge sampling valid_i to the edge asserting valid_o; defaults give L=18.
- busy_o rises on the acceptance edge and falls on the edge asserting valid_o.
- A valid_i present in the valid_o cycle is accepted with no overrun, so back-to-back throughput is one set per L cycles.
- valid_o lasts exactly one cycle.
- Minimum valid_i spacing for no overrun is L cycles; at 1 MHz on 200 MHz, this requires L ≤ 200.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
- Defaults, data_i ch0=100, ch1=-512 → valid_o exactly 18 cycles later, product_o ch0=300, ch1=-1536, busy_o high for those 18 cycles.
- CONST_FACTOR=-128 (others default), ch0=-512, ch1=511 → ch0=65536, ch1=-65408.
- CONST_FACTOR=3, SHIFT=2, OUT_WIDTH=10, one set per channel pair {5,-5}, then {-2,0} → {4,-4}, then {-1,0}, checking round-half-up.
- CONST_FACTOR=127, SHIFT=0, OUT_WIDTH=12, ch0=100, ch1=-100 → ch0=2047, ch1=-2048 (saturated).
- Overrun: second valid_i 5 cycles after acceptance → ignored, overrun_o=1 and stays 1, first result unchanged. A third valid_i in the valid_o cycle is accepted and its result appears L cycles later.
- Reset asserted 10 cycles after acceptance → no valid_o, product_o=0, busy_o=0, overrun_o=0. The next valid_i completes normally after L cycles.
